cla_serial_add_ctrl: RTL and testbench

//   Sequences one CLA_4_Bit slice to add or subtract WIDTH-bit operands, one nibble per cycle, LSB nibble first.

---
 rtl/cla_serial_add_ctrl_pkg.sv | 13 +
 rtl/cla_serial_add_ctrl_cla4.sv | 34 +++
 rtl/cla_serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_serial_add_ctrl_pkg.sv
// Shared types for the nibble-serial CLA adder controller.
// Holds the FSM encoding and the default operand width.
package cla_serial_add_ctrl_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_serial_add_ctrl_cla4.sv
// 4-bit carry-lookahead slice: sum bits plus block generate/propagate.
// The block carry-out is formed by the caller as G | P & C_in.
module cla_serial_add_ctrl_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       g_o,
  output logic       p_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c;

  assign g_o = g[3] | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
  assign p_o = &p;

endmodule

// File: rtl/cla_serial_add_ctrl.sv
// Multi-cycle WIDTH-bit add/sub built from one 4-bit CLA slice,
// one nibble per cycle, LSB nibble first, start/done handshake.
module cla_serial_add_ctrl
  import cla_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             c_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q;
  logic             fin_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] s_nib;
  logic       blk_g;
  logic       blk_p;
  logic       cy_d;

  assign a_nib = a_q[cnt_q*4 +: 4];
  assign b_nib = b_q[cnt_q*4 +: 4];
  assign cy_d  = blk_g | (blk_p & cy_q);

  cla_serial_add_ctrl_cla4 u_cla4 (
    .a_i (a_nib),
    .b_i (b_nib),
    .c_i (cy_q),
    .s_o (s_nib),
    .g_o (blk_g),
    .p_o (blk_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      fin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            cy_q    <= sub | c_in;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!fin_q) begin
            sum_q[cnt_q*4 +: 4] <= s_nib;
            cy_q <= cy_d;
            if (cnt_q == LAST) fin_q <= 1'b1;
            else               cnt_q <= cnt_q + 1'b1;
          end else begin
            // sum is complete here, so flags see the final MSB nibble
            cout_q  <= cy_q;
            ovf_q   <= (a_q[WIDTH-1] ~^ b_q[WIDTH-1])
                     & (sum_q[WIDTH-1] ^ a_q[WIDTH-1]);
            zero_q  <= ~|sum_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign c_out    = cout_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Bench for cla_serial_add_ctrl at WIDTH=32 and WIDTH=8.
// Results are compared against an arithmetic reference model.
module tb_cla_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        st32, sub32, ci32;
  logic [31:0] a32, b32;
  logic        busy32, done32, co32, ov32, z32;
  logic [31:0] sum32;

  logic        st8, sub8, ci8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, co8, ov8, z8;
  logic [7:0]  sum8;

  bit          sel8;
  logic        o_busy, o_done, o_co, o_ov, o_z;
  logic [31:0] o_sum;

  int pass_n = 0;
  int tot_n  = 0;

  longint unsigned e_sum;
  bit e_co, e_ov, e_z;

  always #5 clk = ~clk;

  cla_serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st32), .sub(sub32),
    .c_in(ci32), .a(a32), .b(b32), .busy(busy32),
    .done(done32), .sum(sum32), .c_out(co32),
    .overflow(ov32), .zero(z32)
  );

  cla_serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .sub(sub8),
    .c_in(ci8), .a(a8), .b(b8), .busy(busy8),
    .done(done8), .sum(sum8), .c_out(co8),
    .overflow(ov8), .zero(z8)
  );

  always_comb begin
    o_busy = busy32;
    o_done = done32;
    o_sum  = sum32;
    o_co   = co32;
    o_ov   = ov32;
    o_z    = z32;
    if (sel8) begin
      o_busy = busy8;
      o_done = done8;
      o_sum  = {24'd0, sum8};
      o_co   = co8;
      o_ov   = ov8;
      o_z    = z8;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s w%0d got=%0h exp=%0h",
                  tag, sel8 ? 8 : 32, got, exp);
  endtask

  task automatic model(input int w, input logic [31:0] a,
                       input logic [31:0] b, input bit s,
                       input bit c);
    longint unsigned m, t;
    longint sa, sb, r, hi, lo;
    m  = (64'd1 << w) - 64'd1;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    if (!s) begin
      t     = longint'(a) + longint'(b) + longint'(c);
      e_sum = t & m;
      e_co  = ((t >> w) & 64'd1) != 0;
      r     = sa + sb + longint'(c);
    end else begin
      e_sum = longint'(longint'(a) - longint'(b)) & m;
      e_co  = a >= b;
      r     = sa - sb;
    end
    e_ov = (r > hi) || (r < lo);
    e_z  = e_sum == 0;
  endtask

  task automatic issue(input bit is8, input logic [31:0] a,
                       input logic [31:0] b, input bit s,
                       input bit c);
    sel8 = is8;
    if (is8) begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = s; ci8 = c; st8 = 1'b1;
      model(8, {24'd0, a[7:0]}, {24'd0, b[7:0]}, s, c);
    end else begin
      a32 = a; b32 = b; sub32 = s; ci32 = c; st32 = 1'b1;
      model(32, a, b, s, c);
    end
    @(posedge clk); #1;
    st8 = 1'b0;
    st32 = 1'b0;
    check("busy_acc", 64'(o_busy), 64'd1);
    check("sum_clr", 64'(o_sum), 64'd0);
    check("done_clr", 64'(o_done), 64'd0);
  endtask

  task automatic finish(input bit intrude);
    int n = 0;
    int lat = sel8 ? 3 : 9;
    while (!o_done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (intrude && n == 3) begin
        a32 = $urandom; b32 = $urandom;
        sub32 = 1'($urandom); ci32 = 1'($urandom);
        st32 = 1'b1;
      end
      if (intrude && n == 4) st32 = 1'b0;
    end
    check("latency", 64'(n), 64'(lat));
    check("sum", 64'(o_sum), e_sum);
    check("c_out", 64'(o_co), 64'(e_co));
    check("overflow", 64'(o_ov), 64'(e_ov));
    check("zero", 64'(o_z), 64'(e_z));
    check("busy_done", 64'(o_busy), 64'd0);
  endtask

  task automatic op(input bit is8, input logic [31:0] a,
                    input logic [31:0] b, input bit s,
                    input bit c, input bit intrude,
                    input bit b2b);
    sel8 = is8;
    if (b2b) begin
      check("done_b2b", 64'(o_done), 64'd1);
    end else begin
      @(posedge clk); #1;
      check("done_pulse", 64'(o_done), 64'd0);
    end
    issue(is8, a, b, s, c);
    finish(intrude);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    st32 = 0; sub32 = 0; ci32 = 0; a32 = 0; b32 = 0;
    st8 = 0; sub8 = 0; ci8 = 0; a8 = 0; b8 = 0;
    sel8 = 0;
    #3;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_sum", 64'(sum32), 64'd0);
    check("rst_flags", 64'({co32, ov32, z32}), 64'd0);
    check("rst_sum8", 64'(sum8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    op(0, 32'd12, 32'd3, 0, 0, 0, 0);
    check("t1_sum", 64'(o_sum), 64'd15);
    op(0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    check("t2_zero", 64'(o_z), 64'd1);
    op(0, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0);
    check("t3_ovf", 64'(o_ov), 64'd1);
    op(0, 32'd5, 32'd9, 1, 0, 0, 0);
    check("t3_sub", 64'(o_sum), 64'hFFFF_FFFC);

    op(0, 32'h1234_5678, 32'h0FED_CBA9, 0, 1, 1, 0);
    op(0, 32'h8000_0000, 32'h0000_0001, 1, 0, 0, 1);

    sel8 = 0;
    @(posedge clk); #1;
    issue(0, 32'hDEAD_BEEF, 32'h1357_9BDF, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy32), 64'd0);
    check("arst_sum", 64'(sum32), 64'd0);
    check("arst_flags", 64'({co32, ov32, z32, done32}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done32) seen++;
    end
    check("arst_nodone", 64'(seen), 64'd0);
    op(0, 32'hCAFE_0001, 32'h3501_FFFF, 0, 1, 0, 0);

    op(1, 32'h0D, 32'h0D, 0, 1, 0, 0);
    check("t6_sum", 64'(o_sum), 64'h1B);

    for (int i = 0; i < 1000; i++)
      op(1, $urandom, $urandom, 1'($urandom), 1'($urandom),
         0, i > 0 && $urandom_range(0, 3) == 0);
    for (int i = 0; i < 200; i++)
      op(0, $urandom, $urandom, 1'($urandom), 1'($urandom),
         0, i > 0 && $urandom_range(0, 3) == 0);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
